// File: rtl/pe_add_arbiter.sv
// Round-robin arbiter sharing one 64-bit carry-lookahead adder among NUM_REQ requesters.
// Optional macro PE_ADD_CARRY_CHAIN_EN adds per-requester carry chaining via req_chain.
module pe_add_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*64-1:0]  req_a,
  input  logic [NUM_REQ*64-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_cin,
`ifdef PE_ADD_CARRY_CHAIN_EN
  input  logic [NUM_REQ-1:0]     req_chain,
`endif
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [63:0]            rsp_sum,
  output logic                   rsp_cout,
  output logic                   busy
);

  // Kogge-Stone prefix carry tree; returns {cout, sum}.
  function automatic logic [64:0] cla64(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin);
    logic [63:0] g, p, g_n, p_n, c;
    g = a & b;
    p = a | b;
    for (int l = 0; l < 6; l++) begin
      g_n = g;
      p_n = p;
      for (int i = (1 << l); i < 64; i++) begin
        g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p_n[i] = p[i] & p[i - (1 << l)];
      end
      g = g_n;
      p = p_n;
    end
    c = g | (p & {64{cin}});
    return {c[63], a ^ b ^ {c[62:0], cin}};
  endfunction

  logic              op_vld_q, op_vld_d;
  logic [63:0]       op_a_q, op_a_d;
  logic [63:0]       op_b_q, op_b_d;
  logic              op_cin_q, op_cin_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic              res_vld_q, res_vld_d;
  logic [63:0]       res_sum_q, res_sum_d;
  logic              res_cout_q, res_cout_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [ID_W-1:0]   last_q, last_d;
`ifdef PE_ADD_CARRY_CHAIN_EN
  logic [NUM_REQ-1:0] chain_c_q, chain_c_d;
`endif

  logic               advance;
  logic               accept_en;
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] eligible;
  logic               handshake;
  logic [64:0]        add_res;

  assign add_res   = cla64(op_a_q, op_b_q, op_cin_q);
  assign advance   = op_vld_q & (~res_vld_q | rsp_ready);
  assign accept_en = (~op_vld_q | advance) & ~rst;

  always_comb begin
    eligible = req_valid;
`ifdef PE_ADD_CARRY_CHAIN_EN
    // A chained requester waits until its previous carry has left stage 1.
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_chain[i] && op_vld_q && (op_id_q == ID_W'(i))) eligible[i] = 1'b0;
    end
`endif
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      if (!grant_found && eligible[(int'(last_q) + k) % int'(NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(last_q) + k) % int'(NUM_REQ));
      end
    end
    req_ready = '0;
    if (grant_found) req_ready[grant_id] = accept_en;
  end

  assign handshake = grant_found & accept_en;

  always_comb begin
    op_vld_d   = op_vld_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_cin_d   = op_cin_q;
    op_id_d    = op_id_q;
    last_d     = last_q;
    res_vld_d  = res_vld_q;
    res_sum_d  = res_sum_q;
    res_cout_d = res_cout_q;
    res_id_d   = res_id_q;
`ifdef PE_ADD_CARRY_CHAIN_EN
    chain_c_d  = chain_c_q;
`endif

    if (advance) begin
      res_vld_d  = 1'b1;
      res_sum_d  = add_res[63:0];
      res_cout_d = add_res[64];
      res_id_d   = op_id_q;
`ifdef PE_ADD_CARRY_CHAIN_EN
      chain_c_d[op_id_q] = add_res[64];
`endif
    end else if (res_vld_q && rsp_ready) begin
      res_vld_d = 1'b0;
    end

    if (handshake) begin
      op_vld_d = 1'b1;
      op_a_d   = req_a[grant_id*64 +: 64];
      op_b_d   = req_b[grant_id*64 +: 64];
`ifdef PE_ADD_CARRY_CHAIN_EN
      op_cin_d = req_chain[grant_id] ? chain_c_q[grant_id] : req_cin[grant_id];
`else
      op_cin_d = req_cin[grant_id];
`endif
      op_id_d  = grant_id;
      last_d   = grant_id;
    end else if (advance) begin
      op_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_vld_q   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_cin_q   <= 1'b0;
      op_id_q    <= '0;
      res_vld_q  <= 1'b0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_id_q   <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
`ifdef PE_ADD_CARRY_CHAIN_EN
      chain_c_q  <= '0;
`endif
    end else begin
      op_vld_q   <= op_vld_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_cin_q   <= op_cin_d;
      op_id_q    <= op_id_d;
      res_vld_q  <= res_vld_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
      res_id_q   <= res_id_d;
      last_q     <= last_d;
`ifdef PE_ADD_CARRY_CHAIN_EN
      chain_c_q  <= chain_c_d;
`endif
    end
  end

  assign rsp_valid = res_vld_q;
  assign rsp_id    = res_id_q;
  assign rsp_sum   = res_sum_q;
  assign rsp_cout  = res_cout_q;
  assign busy      = op_vld_q | res_vld_q;

endmodule
